// File: rtl/wb_sram_pkg.sv
// -----------------------------------------------------------------------------
// wb_sram_pkg
// Shared types and constants for the Wishbone on-chip SRAM:
//   - Wishbone master-to-slave / slave-to-master request/response structs
//   - bus width constants (WB_DATA_W, WB_SEL_W)
//   - FSM state encoding
//   - sel_mask(): expands a byte-select vector to a 32-bit lane mask
// -----------------------------------------------------------------------------
package wb_sram_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // Master request: only addr, data, sel, we, stb and cyc are used by the SRAM.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_SEL_W-1:0]  sel;
    logic                 we;
    logic                 stb;
    logic                 cyc;
  } wb_m2s_t;

  // Slave response.
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic                 ack;
  } wb_s2m_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Each set sel bit keeps the corresponding byte lane; cleared bits read 0x00.
  function automatic logic [WB_DATA_W-1:0] sel_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DATA_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < WB_SEL_W; k++) begin
      mask[8*k +: 8] = {8{sel[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_sram_lane.sv
// -----------------------------------------------------------------------------
// wb_sram_lane
// One byte lane of the SRAM: 8 bits x DEPTH_WORDS, synchronous write and
// registered read, written so synthesis maps it onto block RAM.
// Ports:
//   i_clk    clock
//   wr_en    write wr_data to mem[idx] on this edge
//   rd_en    capture mem[idx] into rd_data on this edge
//   idx      word index
//   wr_data  byte to write
//   rd_data  registered read byte
// -----------------------------------------------------------------------------
module wb_sram_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH_WORDS];

  // NOTE: no reset on the array or its read register: a reset here would stop
  // the tools mapping it onto block RAM, and the top masks rd_data until ACK.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/wb_sram.sv
// -----------------------------------------------------------------------------
// wb_sram
// Parametrised Wishbone slave SRAM: word-addressed, byte-lane writes,
// registered reads, registered single-cycle ACK, optional wait states.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (aligned to 4*DEPTH_WORDS)
//   WAIT_CYCLES  extra cycles between accept and ACK (0..15), only when
//                OC_RAM_WAIT_EN is defined
// Ports:
//   i_clk     clock, rising edge
//   i_rstn    synchronous active-low reset
//   i_m2s_wb  master request (addr, data, sel, we, stb, cyc)
//   o_s2m_wb  slave response (data, ack)
// Build option:
//   OC_RAM_WAIT_EN  compiles in the WAIT state and its 4-bit down-counter.
// -----------------------------------------------------------------------------
module wb_sram
  import wb_sram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic    i_clk,
  input  logic    i_rstn,
  input  wb_m2s_t i_m2s_wb,
  output wb_s2m_t o_s2m_wb
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                state;
  logic                  ack_q;
  logic                  we_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [WB_DATA_W-1:0]  rd_word;
  logic [WB_ADDR_W-1:0]  offset;
  logic [IDX_W-1:0]      idx;
  logic                  accept;

  // Out-of-window addresses alias by truncation; addr[1:0] is carried by sel.
  assign offset = i_m2s_wb.addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

  // Gated with reset so a request held during reset neither writes nor reads.
  assign accept = i_rstn && (state == ST_IDLE) && i_m2s_wb.cyc && i_m2s_wb.stb;

  for (genvar k = 0; k < WB_SEL_W; k++) begin : g_lane
    wb_sram_lane #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
    ) u_lane (
      .i_clk   (i_clk),
      .wr_en   (accept && i_m2s_wb.we && i_m2s_wb.sel[k]),
      .rd_en   (accept && !i_m2s_wb.we),
      .idx     (idx),
      .wr_data (i_m2s_wb.data[8*k +: 8]),
      .rd_data (rd_word[8*k +: 8])
    );
  end

`ifdef OC_RAM_WAIT_EN
  logic [3:0] wait_cnt;
`else
  // WAIT_CYCLES has no effect in this build.
  logic [3:0] unused_wait_cycles;
  assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
`ifdef OC_RAM_WAIT_EN
      wait_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q  <= i_m2s_wb.we;
            sel_q <= i_m2s_wb.sel;
`ifdef OC_RAM_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end
`else
            state <= ST_ACK;
            ack_q <= 1'b1;
`endif
          end
        end
        ST_WAIT: begin
`ifdef OC_RAM_WAIT_EN
          // A cyc drop abandons the cycle; any write has already been committed.
          if (!i_m2s_wb.cyc) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_ACK: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Output is built only from registers. Read data is shown while ACK is high
  // for a read; writes and all other states return zero.
  assign o_s2m_wb.ack  = ack_q;
  assign o_s2m_wb.data = (ack_q && !we_q) ? (rd_word & sel_mask(sel_q)) : '0;

  // High offset bits alias away and the byte offset is carried by sel.
  logic [WB_ADDR_W-IDX_W-1:0] unused_offset;
  assign unused_offset = {offset[WB_ADDR_W-1:IDX_W+2], offset[1:0]};

endmodule

// File: tb/tb_wb_sram.sv
// -----------------------------------------------------------------------------
// tb_wb_sram
// Directed bench for wb_sram with DEPTH_WORDS=256, BASE_ADDR=0x2000,
// WAIT_CYCLES=3. Expected ACK latency is 1 cycle, or 1+3 with OC_RAM_WAIT_EN.
// -----------------------------------------------------------------------------
module tb_wb_sram;
  import wb_sram_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef OC_RAM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic    i_clk = 1'b0;
  logic    i_rstn;
  wb_m2s_t m2s;
  wb_s2m_t s2m;

  int total = 0;
  int bad   = 0;

  wb_sram #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (3)
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_m2s_wb (m2s),
    .o_s2m_wb (s2m)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction. Inputs change #1 after a rising edge; the next
  // edge is the accept edge (k=1). ACK is expected to be visible after edge 1+W.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel,
                        output logic [31:0] rdata);
    int  k;
    bit  got;
    m2s = '{addr: addr, data: data, sel: sel, we: we, stb: 1'b1, cyc: 1'b1};
    k   = 0;
    got = 0;
    while (!got && k < 20) begin
      @(posedge i_clk); #1;
      k++;
      if (s2m.ack) got = 1;
    end
    check({tag, "_latency"}, 32'(k), 32'(1 + W));
    rdata   = s2m.data;
    m2s.stb = 1'b0;
    m2s.cyc = 1'b0;
    @(posedge i_clk); #1;
    check({tag, "_ack_width"}, {31'd0, s2m.ack}, 32'd0);
    check({tag, "_idle_data"}, s2m.data, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int ack_edge [4];
    int n_ack;
    int e;

    // Reset held 3 cycles with a live request: no ACK, data stays 0.
    i_rstn = 1'b0;
    m2s    = '{addr: BASE, data: 32'h0, sel: 4'hF, we: 1'b0, stb: 1'b1, cyc: 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      check("reset_ack", {31'd0, s2m.ack}, 32'd0);
      check("reset_data", s2m.data, 32'd0);
    end
    i_rstn = 1'b1;
    access("first_after_reset", 1'b0, BASE, 32'h0, 4'hF, rd);

    // Byte-lane merge and masked reads.
    access("wr_full", 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, rd);
    access("wr_lane2", 1'b1, BASE + 32'h10, 32'h0055_0000, 4'b0100, rd);
    access("rd_full", 1'b0, BASE + 32'h10, 32'h0, 4'b1111, rd);
    check("rd_full_data", rd, 32'hDE55_BEEF);
    access("rd_sel1010", 1'b0, BASE + 32'h10, 32'h0, 4'b1010, rd);
    check("rd_sel1010_data", rd, 32'hDE00_BE00);

    // sel=0 write is acknowledged but changes nothing; addr[1:0] is ignored.
    access("wr_sel0", 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, rd);
    access("rd_unaligned", 1'b0, BASE + 32'h13, 32'h0, 4'b1111, rd);
    check("rd_after_sel0", rd, 32'hDE55_BEEF);

    // 256 words span 0x400 bytes, so BASE+0x400 aliases word 0.
    access("wr_alias", 1'b1, BASE + 32'h400, 32'h1234_5678, 4'b1111, rd);
    access("rd_alias", 1'b0, BASE, 32'h0, 4'b1111, rd);
    check("rd_alias_data", rd, 32'h1234_5678);

    // Back-to-back writes with stb held high; the address advances on each ACK.
    ack_edge = '{default: 0};
    n_ack    = 0;
    e        = 0;
    m2s = '{addr: BASE + 32'h20, data: 32'hA0A0_0000, sel: 4'hF, we: 1'b1, stb: 1'b1, cyc: 1'b1};
    while (n_ack < 4 && e < 60) begin
      @(posedge i_clk); #1;
      e++;
      if (s2m.ack) begin
        ack_edge[n_ack] = e;
        n_ack++;
        m2s.addr = BASE + 32'h20 + 32'(4 * n_ack);
        m2s.data = 32'hA0A0_0000 + 32'(n_ack);
      end
    end
    m2s.stb = 1'b0;
    m2s.cyc = 1'b0;
    check("b2b_ack_count", 32'(n_ack), 32'd4);
    check("b2b_first_latency", 32'(ack_edge[0]), 32'(1 + W));
    for (int i = 1; i < 4; i++) begin
      check("b2b_spacing", 32'(ack_edge[i] - ack_edge[i-1]), 32'(2 + W));
    end
    @(posedge i_clk); #1;
    for (int i = 0; i < 4; i++) begin
      access("b2b_rd", 1'b0, BASE + 32'h20 + 32'(4 * i), 32'h0, 4'hF, rd);
      check("b2b_rd_data", rd, 32'hA0A0_0000 + 32'(i));
    end

`ifdef OC_RAM_WAIT_EN
    // Abort in WAIT: cyc drops before edge N+2; no ACK, write still committed.
    begin
      int acks_seen;
      acks_seen = 0;
      m2s = '{addr: BASE + 32'h30, data: 32'hCAFE_F00D, sel: 4'hF, we: 1'b1, stb: 1'b1, cyc: 1'b1};
      @(posedge i_clk); #1;   // edge N: accept
      @(posedge i_clk); #1;   // edge N+1
      m2s.stb = 1'b0;
      m2s.cyc = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge i_clk); #1;
        if (s2m.ack) acks_seen++;
      end
      check("abort_no_ack", 32'(acks_seen), 32'd0);
      access("after_abort_rd", 1'b0, BASE + 32'h30, 32'h0, 4'hF, rd);
      check("abort_write_committed", rd, 32'hCAFE_F00D);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram.md
# wb_sram

Parametrised Wishbone slave on-chip SRAM, the successor to the fixed 4 KiB combinational-read RAM. Provides word-addressed storage of configurable depth with arbitrary byte-lane writes, registered reads, a registered single-cycle ACK pulse and optional wait states. Sits on the Wishbone interconnect as code or data memory for the RV32I core.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_CYCLES, 2: extra cycles inserted between accept and ACK; range 0..15; used only with OC_RAM_WAIT_EN.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_m2s_wb  in  `WB_M2S  master request; fields used: addr, data, sel, we, stb, cyc.
- o_s2m_wb  out  `WB_S2M  slave response; fields driven: data, ack.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: request accepted when cyc & stb. Accept latches we, sel and word index.
  - Next state is WAIT when OC_RAM_WAIT_EN is defined and WAIT_CYCLES > 0; otherwise ACK.
- WAIT: down-counter is loaded with WAIT_CYCLES-1 at accept and decrements each cycle.
  - Moves to ACK when the counter reaches 0.
  - If cyc drops, returns to IDLE with no ACK.
- ACK: ack = 1 for exactly one cycle, then IDLE unconditionally.
  - stb still high in that following IDLE cycle is a new request.
- Word index = (addr - BASE_ADDR) >> 2, truncated to IDX_W = $clog2(DEPTH_WORDS) bits.
  - Higher bits are ignored, so out-of-window addresses alias; no error response.
  - addr[1:0] is ignored; sel carries the byte position.
- Write (we=1): on the accept edge, byte lane k of word[index] ← data[8k+7:8k] for each sel[k]=1.
  - Any of the 16 sel patterns is legal; sel=0 writes nothing but still ACKs.
  - The write is committed even if the transaction is later aborted in WAIT.
- Read (we=0): on the accept edge, the word is read into a data register.
  - Lanes with sel[k]=0 read as 0x00.
  - o_s2m_wb data presents the register during ACK and 0 in every other state.
- Memory contents are not reset and are X until written.

## Timing
- Reset (i_rstn=0 at an edge): state=IDLE, ack=0, data=32'h0, wait counter=0. A request in progress is dropped with no ACK.
- Request sampled at edge N.
  - Without waits: ack is high during cycle N+1.
  - With waits: ack is high during cycle N+1+WAIT_CYCLES.
- Peak throughput without waits: one access per 2 cycles.
- Requests are sampled only in IDLE. stb/addr changes in WAIT/ACK are ignored, except a cyc drop in WAIT.
- Write followed by a read of the same word: the read returns the new data; no bypass is needed because the two accesses are at least 2 cycles apart.
- No combinational path from i_m2s_wb to o_s2m_wb.

## Configuration
- OC_RAM_WAIT_EN defined:
  - WAIT state and a 4-bit counter are compiled in.
  - ACK latency is 1+WAIT_CYCLES.
  - WAIT_CYCLES=0 behaves as if the macro were undefined.
- OC_RAM_WAIT_EN undefined: no WAIT state and no counter; ACK latency is fixed at 1; WAIT_CYCLES is ignored.

## Structure
- Shared wishbone package.vh: `WB_M2S / `WB_S2M field macros, unchanged.
- Add to the package: WB_SEL_W=4 and WB_DATA_W=32 constants.
- Local localparams: IDX_W and the state encodings.
- Sub-module wb_sram_lane: one 8-bit × DEPTH_WORDS byte memory.
  - Write enable and registered read output; instantiated 4×, one per lane.
  - Infers block RAM.

## Test plan
- Reset with i_rstn=0 for 3 cycles while stb=cyc=1 → ack=0 and data=0 throughout; first ACK exactly 1 cycle after release (waits off).
- Write 32'hDEAD_BEEF, sel=1111 to BASE+0x10; then write sel=0100, data=32'h0055_0000 to the same address → full-word read returns 32'hDE55_BEEF.
- Read of BASE+0x10 with sel=1010 → data 32'hDE00_BE00; ACK is 1 cycle wide.
- DEPTH_WORDS=256: write 32'h1234_5678 to BASE+0x400 → a read of BASE+0x000 returns 32'h1234_5678 (aliasing).
- OC_RAM_WAIT_EN, WAIT_CYCLES=3: read accepted at edge N → ack only in cycle N+4.
  - Second run: drop cyc at N+2 → no ACK, FSM back in IDLE, next request accepted.
- Back-to-back with stb held high across 4 word writes → 4 ACKs spaced 2 cycles apart; all 4 words read back correctly.
